// File: rtl/idex_stage.sv
// ID/EX pipeline stage: MIPS decode, EX/MEM and MEM/WB operand forwarding, load-use stall; 1-cycle latency.
// Backpressure: stall is raised for one cycle on a load-use hazard, and a bubble is inserted while IF/ID holds.
module idex_stage #(
  parameter int DATAWIDTH = 32,
  parameter int ADWIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_valid,
  input  logic [31:0]          if_instr,
  input  logic [31:0]          if_pc,
  output logic [ADWIDTH-1:0]   rf_a1,
  output logic [ADWIDTH-1:0]   rf_a2,
  input  logic [DATAWIDTH-1:0] rf_rd1,
  input  logic [DATAWIDTH-1:0] rf_rd2,
  input  logic                 exmem_regwrite,
  input  logic [ADWIDTH-1:0]   exmem_dst,
  input  logic [DATAWIDTH-1:0] exmem_data,
  input  logic                 memwb_regwrite,
  input  logic [ADWIDTH-1:0]   memwb_dst,
  input  logic [DATAWIDTH-1:0] memwb_data,
  input  logic                 flush,
  output logic                 stall,
  output logic                 ex_valid,
  output logic                 ex_regwrite,
  output logic                 ex_memread,
  output logic                 ex_memwrite,
  output logic [DATAWIDTH-1:0] ex_op1,
  output logic [DATAWIDTH-1:0] ex_op2,
  output logic [DATAWIDTH-1:0] ex_imm,
  output logic [DATAWIDTH-1:0] ex_pc,
  output logic [ADWIDTH-1:0]   ex_dst,
  output logic [5:0]           ex_opcode,
  output logic [5:0]           ex_funct
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]         opcode;
  logic [ADWIDTH-1:0] rs_addr, rt_addr, rd_addr;

  assign opcode  = if_instr[31:26];
  assign rs_addr = ADWIDTH'(if_instr[25:21]);
  assign rt_addr = ADWIDTH'(if_instr[20:16]);
  assign rd_addr = ADWIDTH'(if_instr[15:11]);
  assign rf_a1   = rs_addr;
  assign rf_a2   = rt_addr;

  logic               dec_known, dec_rt_src, dec_wr, dec_mr, dec_mw, dec_zext;
  logic [ADWIDTH-1:0] dec_dst;

  always_comb begin
    dec_known  = 1'b1;
    dec_rt_src = 1'b0;
    dec_wr     = 1'b0;
    dec_mr     = 1'b0;
    dec_mw     = 1'b0;
    dec_zext   = 1'b0;
    dec_dst    = '0;
    case (opcode)
      OP_RTYPE: begin dec_wr = 1'b1; dec_dst = rd_addr; dec_rt_src = 1'b1; end
      OP_LW:    begin dec_wr = 1'b1; dec_mr = 1'b1; dec_dst = rt_addr; end
      OP_SW:    begin dec_mw = 1'b1; dec_rt_src = 1'b1; end
      OP_BEQ:   dec_rt_src = 1'b1;
      OP_ADDI, OP_SLTI: begin dec_wr = 1'b1; dec_dst = rt_addr; end
      OP_ANDI, OP_ORI:  begin dec_wr = 1'b1; dec_dst = rt_addr; dec_zext = 1'b1; end
      default:  dec_known = 1'b0;
    endcase
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never forwarded.
  function automatic logic [DATAWIDTH-1:0] fwd_sel(
    input logic [ADWIDTH-1:0]   addr,
    input logic [DATAWIDTH-1:0] rf_val,
    input logic                 em_we,
    input logic [ADWIDTH-1:0]   em_dst,
    input logic [DATAWIDTH-1:0] em_dat,
    input logic                 mw_we,
    input logic [ADWIDTH-1:0]   mw_dst,
    input logic [DATAWIDTH-1:0] mw_dat
  );
    logic [DATAWIDTH-1:0] val;
    if (addr == '0)                        val = '0;
    else if (em_we && (em_dst == addr))    val = em_dat;
    else if (mw_we && (mw_dst == addr))    val = mw_dat;
    else                                   val = rf_val;
    return val;
  endfunction

  logic               ex_valid_q, ex_regwrite_q, ex_memread_q, ex_memwrite_q;
  logic               ex_valid_d, ex_regwrite_d, ex_memread_d, ex_memwrite_d;
  logic [DATAWIDTH-1:0] ex_op1_q, ex_op2_q, ex_imm_q, ex_pc_q;
  logic [DATAWIDTH-1:0] ex_op1_d, ex_op2_d, ex_imm_d, ex_pc_d;
  logic [ADWIDTH-1:0] ex_dst_q, ex_dst_d;
  logic [5:0]         ex_opcode_q, ex_opcode_d, ex_funct_q, ex_funct_d;
  logic               load_hit, capture;

  // Only a load sitting in EX can't be forwarded in time; the bubble it causes clears ex_memread.
  assign load_hit = ex_valid_q && ex_memread_q && (ex_dst_q != '0) && if_valid && !flush &&
                    ((dec_known && (rs_addr == ex_dst_q)) || (dec_rt_src && (rt_addr == ex_dst_q)));
  assign capture  = if_valid && !flush && !load_hit;
  assign stall    = load_hit;

  always_comb begin
    ex_valid_d    = capture;
    ex_regwrite_d = capture && dec_wr && (dec_dst != '0);
    ex_memread_d  = capture && dec_mr;
    ex_memwrite_d = capture && dec_mw;
    ex_op1_d      = fwd_sel(rs_addr, rf_rd1, exmem_regwrite, exmem_dst, exmem_data,
                            memwb_regwrite, memwb_dst, memwb_data);
    ex_op2_d      = fwd_sel(rt_addr, rf_rd2, exmem_regwrite, exmem_dst, exmem_data,
                            memwb_regwrite, memwb_dst, memwb_data);
    ex_imm_d      = dec_zext ? DATAWIDTH'(if_instr[15:0]) : DATAWIDTH'($signed(if_instr[15:0]));
    ex_pc_d       = DATAWIDTH'(if_pc);
    ex_dst_d      = dec_dst;
    ex_opcode_d   = opcode;
    ex_funct_d    = if_instr[5:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
      ex_imm_q      <= '0;
      ex_pc_q       <= '0;
      ex_dst_q      <= '0;
      ex_opcode_q   <= '0;
      ex_funct_q    <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_memwrite_q <= ex_memwrite_d;
      ex_op1_q      <= ex_op1_d;
      ex_op2_q      <= ex_op2_d;
      ex_imm_q      <= ex_imm_d;
      ex_pc_q       <= ex_pc_d;
      ex_dst_q      <= ex_dst_d;
      ex_opcode_q   <= ex_opcode_d;
      ex_funct_q    <= ex_funct_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_regwrite = ex_regwrite_q;
  assign ex_memread  = ex_memread_q;
  assign ex_memwrite = ex_memwrite_q;
  assign ex_op1      = ex_op1_q;
  assign ex_op2      = ex_op2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_pc       = ex_pc_q;
  assign ex_dst      = ex_dst_q;
  assign ex_opcode   = ex_opcode_q;
  assign ex_funct    = ex_funct_q;

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: directed scenarios plus randomized traffic against an instruction-level model.
module tb_idex_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, if_valid, flush, stall;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_a1, rf_a2, exmem_dst, memwb_dst, ex_dst;
  logic [31:0] rf_rd1, rf_rd2, exmem_data, memwb_data;
  logic        exmem_regwrite, memwb_regwrite;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc;
  logic [5:0]  ex_opcode, ex_funct;

  logic [31:0] regs [32];
  assign rf_rd1 = regs[rf_a1];
  assign rf_rd2 = regs[rf_a2];

  int checks = 0;
  int errors = 0;

  idex_stage #(.DATAWIDTH(32), .ADWIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .exmem_regwrite(exmem_regwrite), .exmem_dst(exmem_dst), .exmem_data(exmem_data),
    .memwb_regwrite(memwb_regwrite), .memwb_dst(memwb_dst), .memwb_data(memwb_data),
    .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_dst(ex_dst), .ex_opcode(ex_opcode), .ex_funct(ex_funct)
  );

  typedef struct packed {
    logic        valid, regwrite, memread, memwrite;
    logic [31:0] op1, op2, imm, pc;
    logic [4:0]  dst;
    logic [5:0]  opcode, funct;
  } ex_t;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic bit known_op(input logic [5:0] op);
    return op inside {6'h00, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
  endfunction

  function automatic bit writes_rt(input logic [5:0] op);
    return op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23};
  endfunction

  function automatic bit reads_rt(input logic [5:0] op);
    return op inside {6'h00, 6'h04, 6'h2B};
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (exmem_regwrite && exmem_dst == a) return exmem_data;
    if (memwb_regwrite && memwb_dst == a) return memwb_data;
    return regs[a];
  endfunction

  function automatic bit ref_stall(input ex_t prev, input logic [31:0] ins, input logic v, fl);
    logic [5:0] op;
    logic [4:0] rs, rt;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    if (!(prev.valid && prev.memread && prev.dst != 5'd0 && v && !fl)) return 1'b0;
    return (known_op(op) && rs == prev.dst) || (reads_rt(op) && rt == prev.dst);
  endfunction

  function automatic ex_t ref_next(input logic [31:0] ins, pc, input logic v, fl, st);
    ex_t e;
    logic [5:0] op;
    e = '0;
    if (!v || fl || st) return e;
    op = ins[31:26];
    e.valid  = 1'b1;
    e.opcode = op;
    e.funct  = ins[5:0];
    e.pc     = pc;
    e.op1    = ref_operand(ins[25:21]);
    e.op2    = ref_operand(ins[20:16]);
    e.imm    = (op == 6'h0C || op == 6'h0D) ? {16'h0000, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    if (op == 6'h00)        e.dst = ins[15:11];
    else if (writes_rt(op)) e.dst = ins[20:16];
    else                    e.dst = 5'd0;
    e.regwrite = (op == 6'h00 || writes_rt(op)) && e.dst != 5'd0;
    e.memread  = (op == 6'h23);
    e.memwrite = (op == 6'h2B);
    return e;
  endfunction

  task automatic set_fwd(input logic ew, input logic [4:0] ed, input logic [31:0] edat,
                         input logic mw, input logic [4:0] md, input logic [31:0] mdat);
    exmem_regwrite = ew; exmem_dst = ed; exmem_data = edat;
    memwb_regwrite = mw; memwb_dst = md; memwb_data = mdat;
  endtask

  task automatic set_if(input logic v, input logic [31:0] ins, pc, input logic fl);
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_if(1'b1, itype(6'h08, 5'd1, 5'd2, 16'h0010), 32'h40, 1'b0);
    #3;
    checks++;
    if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_dst, stall} !== 10'd0) begin
      errors++; $display("FAIL reset_ctrl got %b%b%b%b dst=%0d stall=%b want zeros",
                         ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_dst, stall);
    end
    tick();
    checks++;
    if ({ex_valid, ex_op1, ex_op2, ex_imm, ex_pc, ex_opcode, ex_funct} !== 141'd0) begin
      errors++; $display("FAIL reset_held_over_edge got valid=%b imm=%h pc=%h want 0", ex_valid, ex_imm, ex_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_if(1'b1, itype(6'h08, 5'd1, 5'd2, 16'h0010), 32'h44, 1'b0);
    tick();
    checks++;
    if ({ex_valid, ex_regwrite, ex_dst, ex_imm, ex_pc} !== {1'b1, 1'b1, 5'd2, 32'h10, 32'h44}) begin
      errors++; $display("FAIL first_capture got valid=%b rw=%b dst=%0d imm=%h pc=%h want 1 1 2 10 44",
                         ex_valid, ex_regwrite, ex_dst, ex_imm, ex_pc);
    end
  endtask

  task automatic test_forward_priority();
    @(negedge clk);
    regs[1] = 32'hAAAA_0001; regs[2] = 32'h2222_0002;
    set_fwd(1'b1, 5'd1, 32'h11, 1'b1, 5'd1, 32'h22);
    set_if(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h100, 1'b0);
    tick();
    checks++;
    if (ex_op1 !== 32'h11) begin errors++; $display("FAIL fwd_exmem_prio got %h want 00000011", ex_op1); end
    checks++;
    if (ex_op2 !== 32'h2222_0002) begin errors++; $display("FAIL fwd_rt_rf got %h want 22220002", ex_op2); end
    checks++;
    if ({ex_valid, ex_regwrite, ex_dst, ex_opcode, ex_funct} !== {1'b1, 1'b1, 5'd3, 6'h00, 6'h20}) begin
      errors++; $display("FAIL add_decode got v=%b rw=%b dst=%0d op=%h fn=%h want 1 1 3 00 20",
                         ex_valid, ex_regwrite, ex_dst, ex_opcode, ex_funct);
    end
    @(negedge clk);
    set_fwd(1'b0, 5'd1, 32'h11, 1'b1, 5'd1, 32'h22);
    tick();
    checks++;
    if (ex_op1 !== 32'h22) begin errors++; $display("FAIL fwd_memwb got %h want 00000022", ex_op1); end
  endtask

  task automatic test_imm();
    @(negedge clk);
    regs[0] = 32'hBAD0_0000;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_if(1'b1, itype(6'h0D, 5'd0, 5'd4, 16'h8000), 32'h200, 1'b0);
    tick();
    checks++;
    if ({ex_imm, ex_op1} !== {32'h0000_8000, 32'd0}) begin
      errors++; $display("FAIL ori_zext got imm=%h op1=%h want 00008000 00000000", ex_imm, ex_op1);
    end
    checks++;
    if ({ex_regwrite, ex_dst} !== {1'b1, 5'd4}) begin
      errors++; $display("FAIL ori_dst got rw=%b dst=%0d want 1 4", ex_regwrite, ex_dst);
    end
    @(negedge clk);
    set_if(1'b1, itype(6'h08, 5'd0, 5'd4, 16'h8000), 32'h204, 1'b0);
    tick();
    checks++;
    if (ex_imm !== 32'hFFFF_8000) begin errors++; $display("FAIL addi_sext got %h want ffff8000", ex_imm); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    set_if(1'b1, rtype(5'd0, 5'd2, 5'd0, 6'h20), 32'h300, 1'b0);
    tick();
    checks++;
    if (ex_op1 !== 32'd0) begin errors++; $display("FAIL zero_operand got %h want 00000000", ex_op1); end
    checks++;
    if ({ex_valid, ex_regwrite} !== 2'b10) begin
      errors++; $display("FAIL zero_dst_nowrite got v=%b rw=%b want 1 0", ex_valid, ex_regwrite);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    regs[1] = 32'h1000_0000; regs[7] = 32'h7777_0007;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_if(1'b1, itype(6'h23, 5'd1, 5'd5, 16'h0004), 32'h400, 1'b0);
    tick();
    checks++;
    if ({ex_memread, ex_regwrite, ex_memwrite, ex_dst, ex_imm} !== {1'b1, 1'b1, 1'b0, 5'd5, 32'd4}) begin
      errors++; $display("FAIL lw_decode got mr=%b rw=%b mw=%b dst=%0d imm=%h want 1 1 0 5 4",
                         ex_memread, ex_regwrite, ex_memwrite, ex_dst, ex_imm);
    end
    @(negedge clk);
    set_if(1'b1, rtype(5'd5, 5'd7, 5'd6, 6'h20), 32'h404, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL stall_load_use got %b want 1", stall); end
    tick();
    checks++;
    if ({ex_valid, ex_memread, ex_regwrite} !== 3'b000) begin
      errors++; $display("FAIL stall_bubble got v=%b mr=%b rw=%b want 0 0 0", ex_valid, ex_memread, ex_regwrite);
    end
    @(negedge clk);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h5555_0005);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL stall_one_cycle got %b want 0", stall); end
    tick();
    checks++;
    if ({ex_valid, ex_op1, ex_op2, ex_dst} !== {1'b1, 32'h5555_0005, 32'h7777_0007, 5'd6}) begin
      errors++; $display("FAIL post_stall_fwd got v=%b op1=%h op2=%h dst=%0d want 1 55550005 77770007 6",
                         ex_valid, ex_op1, ex_op2, ex_dst);
    end
  endtask

  task automatic test_flush_hazard();
    @(negedge clk);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_if(1'b1, itype(6'h23, 5'd1, 5'd5, 16'h0004), 32'h500, 1'b0);
    tick();
    @(negedge clk);
    set_if(1'b1, rtype(5'd5, 5'd7, 5'd6, 6'h20), 32'h504, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_over_stall got %b want 0", stall); end
    tick();
    checks++;
    if ({ex_valid, ex_regwrite, ex_memread} !== 3'b000) begin
      errors++; $display("FAIL flush_bubble got v=%b rw=%b mr=%b want 0 0 0", ex_valid, ex_regwrite, ex_memread);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    regs[1] = 32'h0101_0101; regs[2] = 32'h0202_0202;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_if(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h600, 1'b0);
    tick();
    checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("FAIL midstream_loaded got %b want 1", ex_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_op1, ex_op2, ex_imm, ex_pc,
         ex_dst, ex_opcode, ex_funct, stall} !== 150'd0) begin
      errors++; $display("FAIL midstream_reset got v=%b op1=%h op2=%h pc=%h fn=%h want all zero",
                         ex_valid, ex_op1, ex_op2, ex_pc, ex_funct);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_if(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0]  ops [8] = '{6'h00, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    ex_t         cur, nxt;
    logic [31:0] ins, pc;
    logic        v, fl, hold, exp_stall;
    logic [5:0]  op;
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cur = '0; hold = 1'b0; ins = 32'd0; pc = 32'd0; v = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!hold) begin
        op  = ($urandom_range(0, 9) < 9) ? ops[$urandom_range(0, 7)] : 6'($urandom);
        ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        pc  = $urandom & 32'hFFFF_FFFC;
        v   = ($urandom_range(0, 9) < 8);
      end
      fl = ($urandom_range(0, 9) == 0);
      set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      set_if(v, ins, pc, fl);
      #1;
      exp_stall = ref_stall(cur, ins, v, fl);
      checks++;
      if (stall !== exp_stall) begin
        errors++; $display("FAIL rnd_stall n=%0d got %b want %b instr=%h", n, stall, exp_stall, ins);
      end
      checks++;
      if ({rf_a1, rf_a2} !== ins[25:16]) begin
        errors++; $display("FAIL rnd_rf_addr n=%0d got %0d,%0d want %0d,%0d", n, rf_a1, rf_a2, ins[25:21], ins[20:16]);
      end
      nxt = ref_next(ins, pc, v, fl, exp_stall);
      tick();
      checks++;
      if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite} !== {nxt.valid, nxt.regwrite, nxt.memread, nxt.memwrite}) begin
        errors++; $display("FAIL rnd_ctrl n=%0d got %b%b%b%b want %b%b%b%b instr=%h", n,
                           ex_valid, ex_regwrite, ex_memread, ex_memwrite,
                           nxt.valid, nxt.regwrite, nxt.memread, nxt.memwrite, ins);
      end
      if (nxt.valid) begin
        checks++;
        if ({ex_op1, ex_op2, ex_imm, ex_pc, ex_dst, ex_opcode, ex_funct} !==
            {nxt.op1, nxt.op2, nxt.imm, nxt.pc, nxt.dst, nxt.opcode, nxt.funct}) begin
          errors++; $display("FAIL rnd_payload n=%0d got op1=%h op2=%h imm=%h dst=%0d want op1=%h op2=%h imm=%h dst=%0d",
                             n, ex_op1, ex_op2, ex_imm, ex_dst, nxt.op1, nxt.op2, nxt.imm, nxt.dst);
        end
      end
      cur  = nxt;
      hold = exp_stall;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_forward_priority();
    test_imm();
    test_zero_reg();
    test_load_use();
    test_flush_hazard();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
